// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch slice.
// Holds default widths, the fetch FSM state type and the queue entry layout.
package if_pkg;

  localparam int unsigned IF_XLEN     = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/adder.sv
// Plain modular adder; the sum wraps at 2^XLEN.
module adder #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers, combinational head and
// single-cycle flush. DEPTH must be a power of two, at least 2.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop on a full queue writes the slot being vacated.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: fetches sequentially into a small queue,
// flushes on redirect and halts on a misaligned redirect target.
module if_prefetch
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = IF_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_next,
  output logic [XLEN-1:0] out_inst,
  output logic            misalign
);

  // Same layout as fetch_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_plus4;
  logic            q_full;
  logic            q_empty;
  logic            deq;
  logic            fetch;
  entry_t          enq_entry;
  entry_t          head_entry;

  assign imem_addr = fetch_pc;
  assign misalign  = (state == HALT);
  assign out_valid = !q_empty && !redirect_valid;
  assign deq       = out_valid && out_ready;
  assign fetch     = (state == RUN) && fetch_en && !redirect_valid && (!q_full || deq);

  always_comb begin
    enq_entry      = '0;
    enq_entry.pc   = fetch_pc;
    enq_entry.inst = imem_rdata;
  end

  assign out_pc   = head_entry.pc;
  assign out_inst = head_entry.inst;

  adder #(.XLEN(XLEN)) u_fetch_inc (
    .a   (fetch_pc),
    .b   (FOUR),
    .sum (fetch_pc_plus4)
  );

  adder #(.XLEN(XLEN)) u_head_inc (
    .a   (head_entry.pc),
    .b   (FOUR),
    .sum (out_pc_next)
  );

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (enq_entry),
    .full  (q_full),
    .empty (q_empty),
    .head  (head_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      state    <= RUN;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      state    <= (redirect_pc[1:0] != 2'b00) ? HALT : RUN;
    end else if (fetch) begin
      fetch_pc <= fetch_pc_plus4;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed self-checking bench for if_prefetch with a combinational
// instruction memory returning addr ^ 32'hA5A5_A5A5.
module tb_if_prefetch;

  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [31:0] out_inst;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ PAT;

  if_prefetch #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_next    (out_pc_next),
    .out_inst       (out_inst),
    .misalign       (misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_misalign", 32'(misalign),  32'd0);
    chk("rst_addr",     imem_addr,      32'h0);

    // Fill: no bypass, head appears one cycle after fetch
    fetch_en = 1'b1;
    #1 chk("no_bypass", 32'(out_valid), 32'd0);
    step();
    chk("fill1_valid", 32'(out_valid), 32'd1);
    chk("fill1_pc",    out_pc,         32'h0);
    chk("fill1_inst",  out_inst,       32'h0 ^ PAT);
    step(); step(); step();
    chk("full_addr",    imem_addr, 32'h10);
    chk("full_head_pc", out_pc,    32'h0);
    step();
    chk("full_hold_addr", imem_addr, 32'h10);
    chk("full_hold_pc",   out_pc,    32'h0);

    // Streaming from a full queue: one per cycle, refill keeps it full
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid",   32'(out_valid), 32'd1);
      chk("stream_pc",      out_pc,         32'(4 * i));
      chk("stream_pc_next", out_pc_next,    32'(4 * i + 4));
      chk("stream_inst",    out_inst,       32'(4 * i) ^ PAT);
      step();
    end
    chk("stream_addr",   imem_addr, 32'h20);
    chk("stream_head",   out_pc,    32'h10);

    // Down to 3 entries, then redirect with out_ready high
    fetch_en = 1'b0;
    step();
    out_ready = 1'b0;
    chk("three_head", out_pc,    32'h14);
    chk("three_addr", imem_addr, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    #1 chk("redir_valid_same", 32'(out_valid), 32'd0);
    step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    chk("redir_flushed", 32'(out_valid), 32'd0);
    chk("redir_addr",    imem_addr,      32'h100);
    fetch_en = 1'b1;
    step();
    chk("redir_first_valid", 32'(out_valid), 32'd1);
    chk("redir_first_pc",    out_pc,         32'h100);
    chk("redir_first_inst",  out_inst,       32'h100 ^ PAT);

    // Misaligned redirect halts fetch
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk("mis_flag",  32'(misalign),  32'd1);
    chk("mis_valid", 32'(out_valid), 32'd0);
    chk("mis_addr",  imem_addr,      32'h102);
    step(); step(); step();
    chk("mis_hold_flag",  32'(misalign),  32'd1);
    chk("mis_hold_valid", 32'(out_valid), 32'd0);
    chk("mis_hold_addr",  imem_addr,      32'h102);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("resume_flag", 32'(misalign),  32'd0);
    chk("resume_addr", imem_addr,      32'h200);
    step();
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_pc",    out_pc,         32'h200);

    // Address wrap at the top of the space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc",      out_pc,      32'hFFFF_FFFC);
    chk("wrap_pc_next", out_pc_next, 32'h0);
    chk("wrap_addr1",   imem_addr,   32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wrap_next_pc", out_pc,    32'h0);
    chk("wrap_addr2",   imem_addr, 32'h4);

    // Reset overrides a misaligned redirect with entries queued
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("pre_rst_pc",   out_pc,    32'h40);
    chk("pre_rst_addr", imem_addr, 32'h48);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h302;
    step();
    rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
    chk("rst2_valid",    32'(out_valid), 32'd0);
    chk("rst2_addr",     imem_addr,      32'h0);
    chk("rst2_misalign", 32'(misalign),  32'd0);

    // fetch_en low stops fetching but the queue still drains
    fetch_en = 1'b1;
    step(); step();
    fetch_en = 1'b0; out_ready = 1'b1;
    chk("drain_pc0", out_pc, 32'h0);
    step();
    chk("drain_pc1",   out_pc,         32'h4);
    chk("drain_valid", 32'(out_valid), 32'd1);
    step();
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_addr",  imem_addr,      32'h8);
    step();
    chk("drain_stay",  imem_addr,      32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
